int_src: RTL and testbench
==========================

# int_src

Interrupt source controller placed directly upstream of the interrupt register stage. It synchronizes up to four asynchronous external interrupt lines, records them as pending, masks and prioritizes them, and drives the single active-low request `int_req` that the interrupt register samples. It holds a stable source number `int_vec` while the request is outstanding. The handshake with the downstream stage uses that stage's `int_ack` output.

## Interface
Parameters:
- `EDGE_SEL`, default 4'b1111: per source, 1 = rising-edge triggered, 0 = level triggered (active-high).
- `MASK_RST`, default 4'b0000: reset value of the mask register.

Ports:
- `ck` in 1: clock; all state changes on its rising edge.
- `res` in 1: reset, asynchronous, active-low.
- `irq_in` in 4: external interrupt lines, asynchronous to `ck`, active-high.
- `mask_we` in 1: mask write strobe, sampled each `ck`.
- `mask_wd` in 4: mask write data. A bit value of 1 enables that source.
- `int_ack` in 1: acknowledge from the interrupt register. Goes 1 when the interrupt is taken and returns to 0 at return from interrupt.
- `int_req` out 1: interrupt request to the interrupt register, active-low.
- `int_vec` out 2: number of the requesting or in-service source.
- `int_pend` out 4: pending register, for status reads.
- `int_mask` out 4: current mask register.

## Operation
- **Synchronizer**
  - Two flops per line: `sync1`, then `sync2`.
  - A third flop `sync3` supplies the previous value for edge detection.
- **Pending bit `pend[i]`**
  - Edge source: set when `sync2[i]=1` and `sync3[i]=0`. Cleared when the source is accepted (see ACK_WAIT).
  - If set and clear coincide, set wins, so the new edge is not lost.
  - Level source: `pend[i]` is registered from `sync2[i]` every cycle. Acceptance never clears it; the device must drop its line.
- **Mask**
  - `int_mask` is loaded from `mask_wd` when `mask_we=1`.
  - Masking never clears `pend`. It only blocks the pending bit from being requested.
- **Eligible set and priority**
  - Eligible set is `pend & int_mask`.
  - Fixed priority: source 0 highest, source 3 lowest.
- **FSM states**
  - IDLE:
    - `int_req=1`.
    - If the eligible set is non-zero, latch the highest-priority index into `int_vec` and go to REQ.
  - REQ:
    - `int_req=0`. `int_vec` is frozen.
    - Mask writes and new pending bits do not change `int_vec` or retract the request.
    - On `int_ack=1`: clear `pend[int_vec]` if that source is edge type, and go to ACK_WAIT.
  - ACK_WAIT:
    - `int_req=1`. `int_vec` holds the in-service source.
    - On `int_ack=0`, go to IDLE. Return from interrupt clears ack downstream.
- **No nesting**
  - A new request is raised only from IDLE.
  - Sources pending during service are requested after ack falls, in priority order.
- **Level source deasserted while in REQ**
  - The request stays asserted until acked. This is required because the downstream stage samples `int_req` only on selected cycles.

## Timing
- **Reset values**
  - `int_req=1`, `int_vec=0`, `int_pend=0`, `int_mask=MASK_RST`.
  - All synchronizer flops 0. FSM in IDLE.
  - Reset takes effect immediately and asynchronously, in any state. A request in progress is dropped.
- **Request latency**
  - `irq_in[i]` rises and is first captured at edge E1.
  - `sync2` is valid at E2, and `pend[i]` is set at E3.
  - `int_req=0` and `int_vec` are valid after E4, assuming the source is unmasked and the FSM is in IDLE.
  - Total: 4 clocks.
- **Ack latency**
  - `int_ack=1` sampled at edge A: `int_req=1` and the pend clear happen at A.
- **Re-arm latency**
  - `int_ack=0` sampled at edge B: back in IDLE at B.
  - Next request can assert at B+1.
- **Minimum pulse width**
  - An edge-source pulse must be high for at least 2 `ck` periods to be captured reliably.

## Test plan
- **Single edge source**
  - Stimulus: mask=4'b0001; pulse `irq_in[0]` high for 3 clocks.
  - Required response: `int_pend=4'b0001` after 3 edges, `int_req=0` and `int_vec=0` after 4. Assert `int_ack=1`: `int_req=1` and `int_pend=0` at the next edge. Drop ack: FSM returns to IDLE.
- **Priority**
  - Stimulus: mask=4'b1111; `irq_in[3]` and `irq_in[1]` rise in the same cycle.
  - Required response: `int_vec=1` first. After the ack cycle completes, a second request is raised with `int_vec=3`.
- **Masking**
  - Stimulus: mask=4'b0000; pulse `irq_in[2]`.
  - Required response: `int_pend=4'b0100` and `int_req` stays 1. Write mask=4'b0100: `int_req=0` and `int_vec=2` one clock after the write.
- **Stability during REQ**
  - Stimulus: source 2 requesting, then `irq_in[0]` rises and mask is written to 0.
  - Required response: `int_vec` stays 2 and `int_req` stays 0 until ack.
- **Level source (`EDGE_SEL=4'b1110`)**
  - Stimulus: hold `irq_in[0]` high through the ack cycle.
  - Required response: `pend[0]` stays 1, and the request re-asserts immediately after ack falls. After `irq_in[0]` goes low, `pend[0]=0` 3 clocks later.
- **Reset mid-operation**
  - Stimulus: drive `res=0` while in REQ.
  - Required response: `int_req=1`, `int_pend=0`, `int_mask=MASK_RST` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/int_src.sv
// Interrupt source controller: synchronizes four external interrupt lines,
// records them as pending, masks and prioritizes them, and drives an
// active-low request with a stable source number toward the interrupt
// register stage. One request is outstanding at a time (no nesting).
module int_src #(
  parameter logic [3:0] EDGE_SEL = 4'b1111,
  parameter logic [3:0] MASK_RST = 4'b0000
) (
  input  logic       ck,
  input  logic       res,
  input  logic [3:0] irq_in,
  input  logic       mask_we,
  input  logic [3:0] mask_wd,
  input  logic       int_ack,
  output logic       int_req,
  output logic [1:0] int_vec,
  output logic [3:0] int_pend,
  output logic [3:0] int_mask
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    ACK_WAIT = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] sync3;
  logic [3:0] pend;
  logic [3:0] pend_nxt;
  logic [3:0] mask;
  logic [3:0] elig;
  logic [3:0] acc_clr;
  logic [1:0] vec;

  // Fixed priority encoder: source 0 wins, source 3 loses.
  function automatic logic [1:0] prio_idx(input logic [3:0] e);
    if (e[0])      return 2'd0;
    else if (e[1]) return 2'd1;
    else if (e[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign elig = pend & mask;

  // Two-flop synchronizer per line, plus a third flop holding the previous
  // synchronized value for rising-edge detection.
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      sync1 <= 4'b0;
      sync2 <= 4'b0;
      sync3 <= 4'b0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Next pending value: edge sources latch rising edges until accepted (a
  // coincident new edge beats the clear); level sources simply follow the line.
  always_comb begin
    acc_clr = 4'b0;
    if (state == REQ && int_ack) acc_clr[vec] = 1'b1;
    pend_nxt = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (EDGE_SEL[i]) pend_nxt[i] = (sync2[i] & ~sync3[i]) | (pend[i] & ~acc_clr[i]);
      else             pend_nxt[i] = sync2[i];
    end
  end

  // Pending and mask registers.
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      pend <= 4'b0;
      mask <= MASK_RST;
    end else begin
      pend <= pend_nxt;
      if (mask_we) mask <= mask_wd;
    end
  end

  // State register; the vector is captured only when leaving IDLE so it stays
  // frozen through REQ and ACK_WAIT regardless of mask writes or new edges.
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state <= IDLE;
      vec   <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && elig != 4'b0) vec <= prio_idx(elig);
    end
  end

  // Next-state logic for the request/acknowledge handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (elig != 4'b0) state_nxt = REQ;
      REQ:      if (int_ack)      state_nxt = ACK_WAIT;
      ACK_WAIT: if (!int_ack)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  assign int_req  = (state != REQ);
  assign int_vec  = vec;
  assign int_pend = pend;
  assign int_mask = mask;

endmodule

// File: tb/tb_int_src.sv
// Testbench for int_src: a default (all edge) instance and a level-source
// instance share stimulus; expected vectors are queued when a request is
// provoked and compared when the request appears.
module tb_int_src;

  logic       ck;
  logic       res;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wd;
  logic       int_ack;
  logic       int_req, lvl_req;
  logic [1:0] int_vec, lvl_vec;
  logic [3:0] int_pend, lvl_pend;
  logic [3:0] int_mask, lvl_mask;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_v;
  int cyc;

  int_src dut (
    .ck(ck), .res(res), .irq_in(irq_in), .mask_we(mask_we), .mask_wd(mask_wd),
    .int_ack(int_ack), .int_req(int_req), .int_vec(int_vec),
    .int_pend(int_pend), .int_mask(int_mask)
  );

  int_src #(.EDGE_SEL(4'b1110), .MASK_RST(4'b0000)) dut_lvl (
    .ck(ck), .res(res), .irq_in(irq_in), .mask_we(mask_we), .mask_wd(mask_wd),
    .int_ack(int_ack), .int_req(lvl_req), .int_vec(lvl_vec),
    .int_pend(lvl_pend), .int_mask(lvl_mask)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we = 1'b1;
    mask_wd = m;
    tick();
    mask_we = 1'b0;
  endtask

  // Bounded wait for a request from either instance; returns cycles waited.
  task automatic wait_req(input bit lvl, output int n);
    n = 0;
    while (((lvl ? lvl_req : int_req) !== 1'b0) && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL reset_req: got %b want 1", int_req); end
    total++; if (int_vec !== 2'd0) begin bad++; $display("FAIL reset_vec: got %0d want 0", int_vec); end
    total++; if (int_pend !== 4'b0) begin bad++; $display("FAIL reset_pend: got %b want 0000", int_pend); end
    total++; if (int_mask !== 4'b0) begin bad++; $display("FAIL reset_mask: got %b want 0000", int_mask); end
    res = 1'b1;
    tick();
  endtask

  task automatic test_single_edge();
    write_mask(4'b0001);
    total++; if (int_mask !== 4'b0001) begin bad++; $display("FAIL single_mask: got %b want 0001", int_mask); end
    irq_in[0] = 1'b1;
    exp_q.push_back(2'd0);
    tick(); tick(); tick();
    total++; if (int_pend !== 4'b0001) begin bad++; $display("FAIL single_pend_e3: got %b want 0001", int_pend); end
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL single_req_e3: got %b want 1", int_req); end
    irq_in[0] = 1'b0;
    wait_req(1'b0, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL single_latency: got %0d want 1 more edge", cyc); end
    exp_v = exp_q.pop_front();
    total++; if (int_vec !== exp_v) begin bad++; $display("FAIL single_vec: got %0d want %0d", int_vec, exp_v); end
    int_ack = 1'b1;
    tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL single_ack_req: got %b want 1", int_req); end
    total++; if (int_pend !== 4'b0000) begin bad++; $display("FAIL single_ack_pend: got %b want 0000", int_pend); end
    int_ack = 1'b0;
    tick(); tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL single_idle_req: got %b want 1", int_req); end
  endtask

  task automatic test_priority();
    write_mask(4'b1111);
    irq_in = 4'b1010;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    wait_req(1'b0, cyc);
    total++; if (cyc !== 4) begin bad++; $display("FAIL prio_latency: got %0d want 4", cyc); end
    exp_v = exp_q.pop_front();
    total++; if (int_vec !== exp_v) begin bad++; $display("FAIL prio_first_vec: got %0d want %0d", int_vec, exp_v); end
    int_ack = 1'b1;
    tick();
    total++; if (int_pend !== 4'b1000) begin bad++; $display("FAIL prio_pend_after_ack: got %b want 1000", int_pend); end
    int_ack = 1'b0;
    tick();
    wait_req(1'b0, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL prio_rearm: got %0d want 1", cyc); end
    exp_v = exp_q.pop_front();
    total++; if (int_vec !== exp_v) begin bad++; $display("FAIL prio_second_vec: got %0d want %0d", int_vec, exp_v); end
    int_ack = 1'b1;
    tick();
    total++; if (int_pend !== 4'b0000) begin bad++; $display("FAIL prio_pend_clear: got %b want 0000", int_pend); end
    int_ack = 1'b0;
    irq_in = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_masking();
    write_mask(4'b0000);
    irq_in[2] = 1'b1;
    tick(); tick(); tick();
    irq_in[2] = 1'b0;
    tick();
    total++; if (int_pend !== 4'b0100) begin bad++; $display("FAIL mask_pend: got %b want 0100", int_pend); end
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL mask_blocked_req: got %b want 1", int_req); end
    exp_q.push_back(2'd2);
    write_mask(4'b0100);
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL mask_write_edge_req: got %b want 1", int_req); end
    wait_req(1'b0, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL mask_latency: got %0d want 1", cyc); end
    exp_v = exp_q.pop_front();
    total++; if (int_vec !== exp_v) begin bad++; $display("FAIL mask_vec: got %0d want %0d", int_vec, exp_v); end
  endtask

  task automatic test_stability();
    irq_in[0] = 1'b1;
    write_mask(4'b0000);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (int_req !== 1'b0 || int_vec !== 2'd2) begin
        bad++; $display("FAIL stable_req_vec: cycle %0d got req=%b vec=%0d want req=0 vec=2", k, int_req, int_vec);
      end
      tick();
    end
    total++; if (int_pend !== 4'b0101) begin bad++; $display("FAIL stable_pend: got %b want 0101", int_pend); end
    int_ack = 1'b1;
    tick();
    total++; if (int_req !== 1'b1 || int_pend !== 4'b0001) begin bad++; $display("FAIL stable_ack: got req=%b pend=%b want req=1 pend=0001", int_req, int_pend); end
    int_ack = 1'b0;
    tick(); tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL stable_masked_req: got %b want 1", int_req); end
    exp_q.push_back(2'd0);
    write_mask(4'b0001);
    wait_req(1'b0, cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL stable_unmask_latency: got %0d want 1", cyc); end
    exp_v = exp_q.pop_front();
    total++; if (int_vec !== exp_v) begin bad++; $display("FAIL stable_unmask_vec: got %0d want %0d", int_vec, exp_v); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    irq_in = 4'b0000;
    tick(); tick();
    total++; if (int_pend !== 4'b0000) begin bad++; $display("FAIL stable_final_pend: got %b want 0000", int_pend); end
  endtask

  task automatic test_level();
    res = 1'b0;
    tick();
    res = 1'b1;
    write_mask(4'b0001);
    irq_in[0] = 1'b1;
    exp_q.push_back(2'd0);
    wait_req(1'b1, cyc);
    total++; if (cyc !== 4) begin bad++; $display("FAIL lvl_latency: got %0d want 4", cyc); end
    exp_v = exp_q.pop_front();
    total++; if (lvl_vec !== exp_v) begin bad++; $display("FAIL lvl_vec: got %0d want %0d", lvl_vec, exp_v); end
    int_ack = 1'b1;
    tick();
    total++; if (lvl_req !== 1'b1 || lvl_pend !== 4'b0001) begin bad++; $display("FAIL lvl_ack: got req=%b pend=%b want req=1 pend=0001", lvl_req, lvl_pend); end
    exp_q.push_back(2'd0);
    int_ack = 1'b0;
    tick();
    total++; if (lvl_req !== 1'b1) begin bad++; $display("FAIL lvl_idle_req: got %b want 1", lvl_req); end
    tick();
    total++; if (lvl_req !== 1'b0) begin bad++; $display("FAIL lvl_rearm_req: got %b want 0", lvl_req); end
    exp_v = exp_q.pop_front();
    total++; if (lvl_vec !== exp_v) begin bad++; $display("FAIL lvl_rearm_vec: got %0d want %0d", lvl_vec, exp_v); end
    int_ack = 1'b1;
    tick();
    irq_in[0] = 1'b0;
    tick(); tick();
    total++; if (lvl_pend !== 4'b0001) begin bad++; $display("FAIL lvl_pend_hold: got %b want 0001", lvl_pend); end
    tick();
    total++; if (lvl_pend !== 4'b0000) begin bad++; $display("FAIL lvl_pend_drop: got %b want 0000", lvl_pend); end
    int_ack = 1'b0;
    tick(); tick();
    total++; if (lvl_req !== 1'b1) begin bad++; $display("FAIL lvl_final_req: got %b want 1", lvl_req); end
  endtask

  task automatic test_reset_mid();
    res = 1'b0;
    tick();
    res = 1'b1;
    write_mask(4'b0010);
    irq_in[1] = 1'b1;
    exp_q.push_back(2'd1);
    wait_req(1'b0, cyc);
    total++; if (cyc !== 4) begin bad++; $display("FAIL rstmid_latency: got %0d want 4", cyc); end
    exp_v = exp_q.pop_front();
    total++; if (int_vec !== exp_v) begin bad++; $display("FAIL rstmid_vec: got %0d want %0d", int_vec, exp_v); end
    #3;
    res = 1'b0;
    #1;
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL rstmid_req: got %b want 1", int_req); end
    total++; if (int_pend !== 4'b0000) begin bad++; $display("FAIL rstmid_pend: got %b want 0000", int_pend); end
    total++; if (int_mask !== 4'b0000) begin bad++; $display("FAIL rstmid_mask: got %b want 0000", int_mask); end
    total++; if (int_vec !== 2'd0) begin bad++; $display("FAIL rstmid_vec0: got %0d want 0", int_vec); end
    irq_in = 4'b0000;
    tick();
    res = 1'b1;
    tick();
  endtask

  initial begin
    res     = 1'b0;
    irq_in  = 4'b0000;
    mask_we = 1'b0;
    mask_wd = 4'b0000;
    int_ack = 1'b0;
    test_reset();
    test_single_edge();
    test_priority();
    test_masking();
    test_stability();
    test_level();
    test_reset_mid();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
